// File: rtl/btn_scan_ctrl_if.sv
// Event handshake bundle between the button scanner and its consumer.
//   evt_valid : head entry present (driven by master)
//   evt_kind  : 01 press, 10 release, 11 repeat (driven by master)
//   evt_id    : button index of the head entry (driven by master)
//   evt_ready : consumer accepts the head entry (driven by slave)
interface btn_scan_ctrl_if;
  logic       evt_valid;
  logic [1:0] evt_kind;
  logic [3:0] evt_id;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_kind,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_kind,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/btn_scan_ctrl.sv
// Time-shared debounce scheduler for push-buttons. A single tick divider and a single update
// engine visit the buttons round-robin, maintain debounced levels and emit press, release and
// auto-repeat events through a small FIFO.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   btn_raw   : raw asynchronous button inputs
//   btn_level : debounced levels
//   evt       : event handshake (master side)
//   evt_ovf   : sticky, an event was dropped on a full FIFO
module btn_scan_ctrl #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned TICK_DIV   = 4096,
  parameter int unsigned STABLE     = 16,
  parameter int unsigned RPT_DLY    = 64,
  parameter int unsigned RPT_RATE   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  btn_scan_ctrl_if.master    evt,
  output logic               evt_ovf
);

  localparam int unsigned IdxW  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int unsigned DivW  = $clog2(TICK_DIV);
  localparam int unsigned CntW  = 8;
  localparam int unsigned RptW  = $clog2(RPT_DLY + 1);
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [N_BTN-1:0] sync1, sync2;
  logic [DivW-1:0]  div_q;
  logic [IdxW-1:0]  idx_q;
  logic             tick;
  logic [CntW-1:0]  cnt_q [N_BTN];
  logic [RptW-1:0]  rpt_q [N_BTN];
  logic [N_BTN-1:0] level_q;

  logic             cur_sync, cur_level;
  logic [CntW:0]    cnt_inc;
  logic [RptW:0]    rpt_inc;
  logic [CntW-1:0]  cnt_nxt;
  logic [RptW-1:0]  rpt_nxt;
  logic             flip, rep;
  logic             push;
  logic [1:0]       push_kind;

  logic [5:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_q, rd_q;
  logic [AddrW:0]   count_q;
  logic             empty, full, pop, push_ok;

  assign tick = (div_q == DivW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      div_q <= '0;
      idx_q <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) idx_q <= (idx_q == IdxW'(N_BTN - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Update engine for the button currently addressed by the scheduler.
  always_comb begin
    cur_sync  = sync2[idx_q];
    cur_level = level_q[idx_q];
    cnt_inc   = {1'b0, cnt_q[idx_q]} + 1'b1;
    rpt_inc   = {1'b0, rpt_q[idx_q]} + 1'b1;
    flip      = 1'b0;
    rep       = 1'b0;
    cnt_nxt   = '0;
    rpt_nxt   = rpt_q[idx_q];
    if (cur_sync != cur_level) begin
      if (cnt_inc == (CntW + 1)'(STABLE)) flip = 1'b1;
      else                                cnt_nxt = cnt_inc[CntW-1:0];
    end
    if (flip) begin
      rpt_nxt = '0;
    end else if (cur_level) begin
      // Reload leaves RPT_RATE visits until the next repeat.
      if (rpt_inc == (RptW + 1)'(RPT_DLY)) begin
        rep     = 1'b1;
        rpt_nxt = RptW'(RPT_DLY - RPT_RATE);
      end else begin
        rpt_nxt = rpt_inc[RptW-1:0];
      end
    end
    push      = tick & (flip | rep);
    push_kind = flip ? (cur_level ? 2'b10 : 2'b01) : 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
        rpt_q[i] <= '0;
      end
      level_q <= '0;
    end else if (tick) begin
      cnt_q[idx_q] <= cnt_nxt;
      rpt_q[idx_q] <= rpt_nxt;
      if (flip) level_q[idx_q] <= ~cur_level;
    end
  end

  assign btn_level = level_q;

  // Event FIFO; a push while full only succeeds if the head leaves the same cycle.
  assign empty   = (count_q == '0);
  assign full    = (count_q == (AddrW + 1)'(FIFO_DEPTH));
  assign pop     = ~empty & evt.evt_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= {push_kind, 4'(idx_q)};
        wr_q        <= (wr_q == AddrW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_q <= (rd_q == AddrW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (push && !push_ok) evt_ovf <= 1'b1;
    end
  end

  assign evt.evt_valid = ~empty;
  assign evt.evt_kind  = empty ? 2'b00 : mem_q[rd_q][5:4];
  assign evt.evt_id    = empty ? 4'h0  : mem_q[rd_q][3:0];

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl with N_BTN=4, TICK_DIV=4, STABLE=4, RPT_DLY=6, RPT_RATE=2.
// Stimulus pushes hand-derived events into exp_q; the monitor pops on each accepted handshake.
module tb_btn_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'h0;
  logic [3:0] btn_level;
  logic       evt_ovf;

  btn_scan_ctrl_if evt_bus ();

  btn_scan_ctrl #(
    .N_BTN     (4),
    .TICK_DIV  (4),
    .STABLE    (4),
    .RPT_DLY   (6),
    .RPT_RATE  (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .evt      (evt_bus),
    .evt_ovf  (evt_ovf)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [5:0] exp_q[$];
  int         n;
  logic [5:0] mon_head;
  logic [5:0] stall_head;
  logic       stalled = 1'b0;

  localparam logic [1:0] KPress = 2'b01, KRel = 2'b10, KRep = 2'b11;

  // Posedges since reset release; a visit happens at n%4==0 to button (n/4-1)%4.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input int id);
    exp_q.push_back({kind, 4'(id)});
  endtask

  task automatic tick_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_visit(input int b);
    int  t;
    bit  found;
    t = 0;
    found = 1'b0;
    while (!found && t < 40) begin
      tick_wait();
      t++;
      if (n > 0 && n % 4 == 0 && ((n / 4 - 1) % 4) == b) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL visit_timeout actual=none required=visit_%0d", b);
    end
  endtask

  task automatic wait_level(input int b, input logic val, input int bound, input string name);
    int t;
    t = 0;
    while (btn_level[b] !== val && t < bound) begin
      tick_wait();
      t++;
    end
    check(name, 32'(btn_level[b]), 32'(val));
  endtask

  task automatic wait_drain(input int bound, input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < bound) begin
      tick_wait();
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: compare each accepted event, and head stability while stalled.
  always @(negedge clk) begin
    if (!rst && evt_bus.evt_valid) begin
      mon_head = {evt_bus.evt_kind, evt_bus.evt_id};
      if (evt_bus.evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=%0h required=none", mon_head);
        end else begin
          check("event", 32'(mon_head), 32'(exp_q.pop_front()));
        end
        stalled = 1'b0;
      end else begin
        if (stalled) check("head_stable", 32'(mon_head), 32'(stall_head));
        stalled    = 1'b1;
        stall_head = mon_head;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  logic glitch;

  initial begin
    evt_bus.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    check("rst_valid", 32'(evt_bus.evt_valid), 0);
    check("rst_kind", 32'(evt_bus.evt_kind), 0);
    check("rst_id", 32'(evt_bus.evt_id), 0);
    check("rst_ovf", 32'(evt_ovf), 0);
    check("rst_level", 32'(btn_level), 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean press / release of button 1: flip on the 4th visit, 64 clk after the edge.
    wait_visit(1);
    btn_raw[1] = 1'b1;
    push_exp(KPress, 1);
    repeat (63) tick_wait();
    check("t2_level_early", 32'(btn_level[1]), 0);
    tick_wait();
    check("t2_level_rise", 32'(btn_level[1]), 1);
    check("t2_valid", 32'(evt_bus.evt_valid), 1);
    check("t2_head", 32'({evt_bus.evt_kind, evt_bus.evt_id}), 32'h11);
    btn_raw[1] = 1'b0;
    push_exp(KRel, 1);
    wait_level(1, 1'b0, 100, "t2_level_fall");

    // Bounce on button 2, then settle high.
    glitch = 1'b0;
    for (int c = 0; c < 200; c++) begin
      btn_raw[2] = ((c / 24) % 2 == 0);
      tick_wait();
      if (btn_level[2] !== 1'b0) glitch = 1'b1;
    end
    check("t3_no_glitch", 32'(glitch), 0);
    btn_raw[2] = 1'b1;
    push_exp(KPress, 2);
    wait_level(2, 1'b1, 100, "t3_level_rise");
    btn_raw[2] = 1'b0;
    push_exp(KRel, 2);
    wait_level(2, 1'b0, 100, "t3_level_fall");

    // Hold button 0: repeats at visits +6, +8, +10; let go after visit +7, release at +11.
    wait_visit(0);
    btn_raw[0] = 1'b1;
    push_exp(KPress, 0);
    push_exp(KRep, 0);
    push_exp(KRep, 0);
    push_exp(KRep, 0);
    push_exp(KRel, 0);
    wait_level(0, 1'b1, 100, "t4_level_rise");
    repeat (7) wait_visit(0);
    btn_raw[0] = 1'b0;
    wait_level(0, 1'b0, 100, "t4_level_fall");
    wait_drain(20, "t4_drain");

    // Full FIFO, pop coincides with the btn0 repeat push (148 clk after the edge).
    evt_bus.evt_ready = 1'b0;
    wait_visit(3);
    btn_raw = 4'hF;
    for (int b = 0; b < 4; b++) push_exp(KPress, b);
    repeat (64) tick_wait();
    check("t6_full_valid", 32'(evt_bus.evt_valid), 1);
    repeat (83) tick_wait();
    evt_bus.evt_ready = 1'b1;
    tick_wait();
    check("t6_no_ovf", 32'(evt_ovf), 0);
    btn_raw = 4'h0;
    for (int b = 0; b < 4; b++) push_exp(KRep, b);
    for (int b = 0; b < 4; b++) push_exp(KRep, b);
    push_exp(KRel, 1);
    push_exp(KRel, 2);
    push_exp(KRel, 3);
    push_exp(KRel, 0);
    wait_drain(150, "t6_drain");
    check("t6_ovf_final", 32'(evt_ovf), 0);

    // Backpressure: four presses fill the FIFO, the btn0 repeat is dropped.
    evt_bus.evt_ready = 1'b0;
    wait_visit(3);
    btn_raw = 4'hF;
    for (int b = 0; b < 4; b++) push_exp(KPress, b);
    repeat (147) tick_wait();
    check("t5_ovf_before", 32'(evt_ovf), 0);
    tick_wait();
    check("t5_ovf_set", 32'(evt_ovf), 1);
    repeat (12) tick_wait();
    evt_bus.evt_ready = 1'b1;
    btn_raw = 4'h0;
    for (int b = 0; b < 4; b++) push_exp(KRep, b);
    for (int b = 0; b < 4; b++) push_exp(KRel, b);
    wait_drain(200, "t5_drain");
    check("t5_ovf_sticky", 32'(evt_ovf), 1);
    check("t5_levels", 32'(btn_level), 0);

    // Reset mid-run with events queued.
    evt_bus.evt_ready = 1'b0;
    wait_visit(3);
    btn_raw = 4'hF;
    repeat (70) tick_wait();
    check("t1_pre_valid", 32'(evt_bus.evt_valid), 1);
    check("t1_pre_level", 32'(btn_level), 32'hF);
    rst = 1'b1;
    #1;
    check("t1_valid", 32'(evt_bus.evt_valid), 0);
    check("t1_kind", 32'(evt_bus.evt_kind), 0);
    check("t1_id", 32'(evt_bus.evt_id), 0);
    check("t1_ovf", 32'(evt_ovf), 0);
    check("t1_level", 32'(btn_level), 0);
    btn_raw = 4'h0;
    evt_bus.evt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) tick_wait();
    check("t1_empty_after", 32'(evt_bus.evt_valid), 0);
    check("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
